// File: rtl/ripple_carry_adder32.sv
// ripple_carry_adder32
//   Two's-complement ripple-carry adder built from an explicit chain of 1-bit
//   full-adder cells, plus a one-deep result register with a valid flag.
//
//   Ports:
//     clk, rst_n        rising-edge clock; asynchronous active-low reset
//     a, b              WIDTH-bit operands
//     cin               carry into bit 0
//     in_valid          qualifies a/b/cin for capture into the result register
//     sum, cout         combinational (a + b + cin) mod 2^WIDTH and carry out
//     sum_q, cout_q     registered sum / carry, loaded only when in_valid=1
//     out_valid         in_valid delayed by one cycle
//   Optional (macro RIPPLE_CARRY_ADDER_OVERFLOW_EN):
//     ovf, ovf_q        signed overflow, combinational and registered
//
//   WIDTH legal range 1..64.

// Single full-adder cell; one instance per bit position.
module rca_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module ripple_carry_adder32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             out_valid
`ifdef RIPPLE_CARRY_ADDER_OVERFLOW_EN
  ,
  output logic             ovf,
  output logic             ovf_q
`endif
);

  localparam int STAGES = 1;

  // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      rca_fa_cell u_fa (
        .a  (a[i]),
        .b  (b[i]),
        .ci (c[i]),
        .s  (s[i]),
        .co (c[i+1])
      );
    end
  endgenerate

  // Combinational results: no dependence on clk, rst_n or in_valid.
  assign sum  = s;
  assign cout = c[WIDTH];

`ifdef RIPPLE_CARRY_ADDER_OVERFLOW_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  // For WIDTH=1 this compares cin with the carry out, which still holds.
  assign ovf = c[WIDTH] ^ c[WIDTH-1];
`endif

  // Valid pipeline: vld_pipe[0] is the live input, higher taps are registered.
  logic [STAGES:0] vld_pipe;
  logic [STAGES:1] vld_q;

  assign vld_pipe  = {vld_q, in_valid};
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
    end
  end

  // Result register: loads on in_valid, otherwise holds the last result so a
  // consumer can keep reading it after out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (in_valid) begin
      sum_q  <= sum;
      cout_q <= cout;
    end
  end

`ifdef RIPPLE_CARRY_ADDER_OVERFLOW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (in_valid) begin
      ovf_q <= ovf;
    end
  end
`endif

endmodule

// File: tb/tb_ripple_carry_adder32.sv
// Testbench for ripple_carry_adder32 (WIDTH=32): table-driven vectors,
// seeded random regression against an arithmetic reference, plus hand-written
// reset, hold/valid-gating and asynchronous-reset sequences.
module tb_ripple_carry_adder32;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a, b;
  logic         cin;
  logic         in_valid;
  logic [W-1:0] sum, sum_q;
  logic         cout, cout_q, out_valid;
`ifdef RIPPLE_CARRY_ADDER_OVERFLOW_EN
  logic         ovf, ovf_q;
`endif

  int checks = 0;
  int errors = 0;

  ripple_carry_adder32 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .cout      (cout),
    .sum_q     (sum_q),
    .cout_q    (cout_q),
    .out_valid (out_valid)
`ifdef RIPPLE_CARRY_ADDER_OVERFLOW_EN
    ,
    .ovf       (ovf),
    .ovf_q     (ovf_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[$];

  // Reference: plain wide arithmetic and sign-rule overflow.
  function automatic logic [W:0] ref_add(logic [W-1:0] x, logic [W-1:0] y, logic ci);
    logic [W:0] r;
    r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    return r;
  endfunction

  function automatic logic ref_ovf(logic [W-1:0] x, logic [W-1:0] y, logic ci);
    logic [W:0] r;
    r = ref_add(x, y, ci);
    return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (a=0x%08h b=0x%08h cin=%0b)",
               name, act, exp, a, b, cin);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic v);
    @(negedge clk);
    a = x; b = y; cin = ci; in_valid = v;
    #1;
  endtask

  initial begin
    logic [W:0]   r;
    logic [W-1:0] ra, rb;

    // Directed table: expectations written out as constants.
    vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0});
    vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0});

    // Reset with activity on the inputs.
    rst_n = 1'b0; in_valid = 1'b1; a = 5; b = 7; cin = 1'b0;
    #1;
    check("rst_sum_q", 64'(sum_q), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = W'(5 + i); b = W'(7 + 2 * i);
      #1;
      check("rst_comb_sum", 64'(sum), 64'(12 + 3 * i));
      tick();
      check("rst_hold_sum_q", 64'(sum_q), 64'd0);
      check("rst_hold_cout_q", 64'(cout_q), 64'd0);
      check("rst_hold_out_valid", 64'(out_valid), 64'd0);
    end

    // Release, first transaction.
    @(negedge clk);
    rst_n = 1'b1; a = 5; b = 7; cin = 1'b0; in_valid = 1'b1;
    #1;
    check("first_sum", 64'(sum), 64'd12);
    tick();
    check("first_sum_q", 64'(sum_q), 64'd12);
    check("first_out_valid", 64'(out_valid), 64'd1);

    // Directed table.
    foreach (vecs[k]) begin
      apply(vecs[k].a, vecs[k].b, vecs[k].cin, 1'b1);
      check("tbl_sum", 64'(sum), 64'(vecs[k].exp_sum));
      check("tbl_cout", 64'(cout), 64'(vecs[k].exp_cout));
`ifdef RIPPLE_CARRY_ADDER_OVERFLOW_EN
      check("tbl_ovf", 64'(ovf), 64'(vecs[k].exp_ovf));
`endif
      tick();
      check("tbl_sum_q", 64'(sum_q), 64'(vecs[k].exp_sum));
      check("tbl_cout_q", 64'(cout_q), 64'(vecs[k].exp_cout));
      check("tbl_out_valid", 64'(out_valid), 64'd1);
`ifdef RIPPLE_CARRY_ADDER_OVERFLOW_EN
      check("tbl_ovf_q", 64'(ovf_q), 64'(vecs[k].exp_ovf));
`endif
    end

    // Seeded random regression, back-to-back valid.
    void'($urandom(32'd1234));
    for (int i = 0; i < 16; i++) begin
      ra = $urandom; rb = $urandom;
      r = ref_add(ra, rb, 1'b0);
      apply(ra, rb, 1'b0, 1'b1);
      check("rnd_sum", 64'(sum), 64'(r[W-1:0]));
      check("rnd_cout", 64'(cout), 64'(r[W]));
`ifdef RIPPLE_CARRY_ADDER_OVERFLOW_EN
      check("rnd_ovf", 64'(ovf), 64'(ref_ovf(ra, rb, 1'b0)));
`endif
      tick();
      check("rnd_sum_q", 64'(sum_q), 64'(r[W-1:0]));
      check("rnd_cout_q", 64'(cout_q), 64'(r[W]));
      check("rnd_out_valid", 64'(out_valid), 64'd1);
    end

    // Hold / valid gating.
    apply(100, 23, 1'b0, 1'b1);
    tick();
    check("hold_load_sum_q", 64'(sum_q), 64'd123);
    check("hold_load_valid", 64'(out_valid), 64'd1);
    apply(1, 1, 1'b0, 1'b0);
    check("hold_comb_sum", 64'(sum), 64'd2);
    tick();
    check("hold_sum_q", 64'(sum_q), 64'd123);
    check("hold_valid_drop", 64'(out_valid), 64'd0);
    tick();
    check("hold_sum_q_2", 64'(sum_q), 64'd123);

    // Asynchronous reset between edges, then restart.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_sum_q", 64'(sum_q), 64'd0);
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_comb_sum", 64'(sum), 64'd2);
    apply(9, 9, 1'b0, 1'b1);
    tick();
    check("async_held_sum_q", 64'(sum_q), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    check("post_rst_idle_valid", 64'(out_valid), 64'd0);
    check("post_rst_idle_sum_q", 64'(sum_q), 64'd0);
    apply(40, 2, 1'b1, 1'b1);
    tick();
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_sum_q", 64'(sum_q), 64'd43);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ripple_carry_adder32.md
Name: ripple_carry_adder32

Overview:
- Parameterised two's-complement ripple-carry adder, default 32 bits.
- Built as an explicit chain of 1-bit full adders; no behavioural "+" on the full width.
- Provides a combinational sum/carry path for same-cycle use and a registered result stage with a valid flag for pipelined datapaths.
- Drop-in arithmetic leaf for ALU and address-generation blocks.

Parameters:
- WIDTH, 32, operand and sum width in bits; legal range 1 to 64.

Ports:
- clk  input  1  rising-edge clock for the result register stage
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in to bit 0; tie 0 for plain addition
- in_valid  input  1  qualifies a/b/cin for capture into the result register
- sum  output  WIDTH  combinational (a + b + cin) mod 2^WIDTH
- cout  output  1  combinational carry out of bit WIDTH-1
- sum_q  output  WIDTH  registered sum
- cout_q  output  1  registered carry out
- out_valid  output  1  registered in_valid; high when sum_q/cout_q hold a fresh result

Behaviour:
- Full adder per bit i: s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]); c[0] = cin.
  - Use a generate loop of full-adder cells; carry propagates LSB to MSB.
- Combinational path:
  - sum = s[WIDTH-1:0], cout = c[WIDTH].
  - Zero clock latency; settles within one combinational delay of any input change.
  - Independent of clk, rst_n and in_valid.
- Arithmetic:
  - Result wraps modulo 2^WIDTH; no saturation.
  - Identical for signed and unsigned operands; cout is the unsigned carry.
- Register stage, on rising clk edge:
  - If in_valid=1: sum_q <= sum, cout_q <= cout.
  - If in_valid=0: sum_q and cout_q hold their previous values.
  - out_valid <= in_valid every cycle.
  - Latency from in_valid to out_valid is exactly 1 cycle; back-to-back valid inputs give back-to-back results at full throughput.
- Reset:
  - rst_n low asynchronously forces sum_q=0, cout_q=0, out_valid=0, regardless of clk.
  - Reset released synchronously into the clock domain by the integrating block.
  - The combinational sum/cout remain functional during reset.
  - Reset asserted mid-stream discards the in-flight result; the first out_valid after release follows the first in_valid sampled after release.
- X-propagation: no special handling; X on any input bit may corrupt that bit and every higher sum bit.

Optional Feature:
- Macro RIPPLE_CARRY_ADDER_OVERFLOW_EN.
- When defined:
  - Adds ports ovf (output, 1, combinational) and ovf_q (output, 1, registered).
  - ovf = c[WIDTH] ^ c[WIDTH-1], the signed two's-complement overflow.
  - ovf_q is captured with the same in_valid enable as sum_q and resets to 0.
- When undefined: the ports do not exist and no extra logic is generated. All other behaviour is identical.

Test Plan:
- Reset: rst_n=0 with in_valid=1, a=5, b=7 toggling -> sum_q=0, cout_q=0, out_valid=0 throughout. After release, a=5, b=7, cin=0 -> sum=12 immediately; sum_q=12 and out_valid=1 one cycle later.
- Wrap/carry: a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1. Also a=0xFFFFFFFF, b=0xFFFFFFFF, cin=1 -> sum=0xFFFFFFFF, cout=1.
- Random regression: 10+ seeded random a/b pairs, cin=0, each held 10 time units.
  - sum checked 1 time unit after apply against (a+b) mod 2^32.
  - sum_q checked after the next edge.
  - On mismatch, print both operands, actual and expected.
- Full carry chain: a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, cout=0. With RIPPLE_CARRY_ADDER_OVERFLOW_EN, ovf=1; a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
- Hold/valid gating:
  - Cycle 1: in_valid=1, a=100, b=23 -> next cycle sum_q=123, out_valid=1.
  - Then in_valid=0, a=1, b=1 -> sum=2 combinationally, but sum_q stays 123 and out_valid drops to 0.
- Async reset mid-stream: assert rst_n=0 between clock edges while sum_q=123 -> sum_q=0, out_valid=0 immediately, without a clock edge.
